// File: rtl/bk_adder_24_pkg.sv
// Shared constants for the 24-bit Brent-Kung adder and its prefix tree.
// The tree depth follows directly from the fixed operand width.
package bk_adder_24_pkg;

    localparam int ADD_W   = 24;
    // Up-sweep spans 2, 4, 8, 16; the down-sweep mirrors them (8, 4, 2, 1).
    localparam int UP_LVLS = 4;

    typedef logic [ADD_W-1:0] word_t;

endpackage

// File: rtl/bk_adder_24_if.sv
// Operand/result bundle for bk_adder_24.
// Handshake: in_valid qualifies a/b/cin on a rising edge; out_valid marks sum/cout one edge later; there is no ready.
interface bk_adder_24_if;
    import bk_adder_24_pkg::*;

    logic  in_valid;
    word_t a;
    word_t b;
    logic  cin;
    word_t sum;
    logic  cout;
    logic  out_valid;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  sum,
        input  cout,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output sum,
        output cout,
        output out_valid
    );

endinterface

// File: rtl/bk_adder_24_prefix_cell.sv
// Prefix-tree nodes: the black cell forms (G,P) o (G',P'); the gray cell
// produces only G and is used where the group propagate is never consumed.
module bk_prefix_cell (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    input  logic p_lo_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);
    assign p_o = p_hi_i & p_lo_i;

endmodule

module bk_prefix_gray_cell (
    input  logic g_hi_i,
    input  logic p_hi_i,
    input  logic g_lo_i,
    output logic g_o
);

    assign g_o = g_hi_i | (p_hi_i & g_lo_i);

endmodule

// File: rtl/bk_adder_24.sv
// 24-bit Brent-Kung adder with carry-in; result and carry-out registered once.
// The prefix tree is purely combinational between the ports and the output register.
module bk_adder_24
    import bk_adder_24_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    bk_adder_24_if.slave bus
);

    word_t g_bit;
    word_t p_bit;

    // Level k of the up-sweep holds spans of 2^k at bits where (i+1) is a multiple of 2^k.
    logic [UP_LVLS:0][ADD_W-1:0] up_g;
    logic [UP_LVLS:0][ADD_W-1:0] up_p;
    logic [UP_LVLS:0][ADD_W-1:0] dn_g;

    word_t grp_g;
    word_t carry;
    word_t sum_d;
    logic  cout_d;
    word_t sum_q;
    logic  cout_q;
    logic  valid_q;
    logic  unused_up_p;

    assign g_bit = bus.a & bus.b;
    assign p_bit = bus.a ^ bus.b;

    // Carry-in is folded into bit 0 so every group generate already includes it.
    assign up_g[0] = {g_bit[ADD_W-1:1], g_bit[0] | (p_bit[0] & bus.cin)};
    assign up_p[0] = p_bit;

    for (genvar k = 1; k <= UP_LVLS; k++) begin : g_up
        localparam int SPAN = 1 << k;
        localparam int HALF = SPAN / 2;
        for (genvar i = 0; i < ADD_W; i++) begin : g_bit_up
            if (((i + 1) % SPAN) == 0) begin : g_node
                bk_prefix_cell u_cell (
                    .g_hi_i (up_g[k-1][i]),
                    .p_hi_i (up_p[k-1][i]),
                    .g_lo_i (up_g[k-1][i-HALF]),
                    .p_lo_i (up_p[k-1][i-HALF]),
                    .g_o    (up_g[k][i]),
                    .p_o    (up_p[k][i])
                );
            end else begin : g_pass
                assign up_g[k][i] = up_g[k-1][i];
                assign up_p[k][i] = up_p[k-1][i];
            end
        end
    end

    assign dn_g[0] = up_g[UP_LVLS];

    // Each bit is completed at most once on the way down: the level whose
    // distance equals the lowest set bit of (i+1), unless already complete.
    for (genvar j = 1; j <= UP_LVLS; j++) begin : g_dn
        localparam int DIST = 1 << (UP_LVLS - j);
        for (genvar i = 0; i < ADD_W; i++) begin : g_bit_dn
            if ((((i + 1) % (2 * DIST)) == DIST) && ((i + 1) > (2 * DIST))) begin : g_node
                bk_prefix_gray_cell u_cell (
                    .g_hi_i (dn_g[j-1][i]),
                    .p_hi_i (up_p[UP_LVLS][i]),
                    .g_lo_i (dn_g[j-1][i-DIST]),
                    .g_o    (dn_g[j][i])
                );
            end else begin : g_pass
                assign dn_g[j][i] = dn_g[j-1][i];
            end
        end
    end

    // Group propagates of completed nodes are never needed past the up-sweep.
    assign unused_up_p = ^up_p[UP_LVLS];

    assign grp_g  = dn_g[UP_LVLS];
    assign carry  = {grp_g[ADD_W-2:0], bus.cin};
    assign sum_d  = p_bit ^ carry;
    assign cout_d = grp_g[ADD_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_bk_adder_24.sv
// Bench for bk_adder_24: a driver pushes expected 25-bit results into a queue;
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_bk_adder_24;
    import bk_adder_24_pkg::*;

    logic clk;
    logic rst;

    bk_adder_24_if bus ();

    bk_adder_24 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [ADD_W:0] exp_q[$];
    logic [ADD_W:0] hold_v;
    logic           rst_at_edge;
    logic           started;
    int             checks;
    int             errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_at_edge <= rst;
        started     <= 1'b1;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic v, input word_t a,
                         input word_t b, input logic c);
        logic [ADD_W:0] e;
        @(posedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        e = {1'b0, a} + {1'b0, b} + {{ADD_W{1'b0}}, c};
        if (v && !r) exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, word_t'($urandom), word_t'($urandom), 1'($urandom));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [ADD_W:0] got;
        logic [ADD_W:0] e;
        if (started === 1'b1) begin
            got = {bus.cout, bus.sum};
            if (rst_at_edge) begin
                hold_v = '0;
                checks++;
                if (got !== '0 || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL reset: got out_valid=%b cout/sum=%h, want out_valid=0 cout/sum=0",
                             bus.out_valid, got);
                end
            end else if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got cout/sum=%h with no add pending", got);
                end else begin
                    e = exp_q.pop_front();
                    hold_v = e;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL add: got cout/sum=%h, want %h", got, e);
                    end
                end
            end else begin
                checks++;
                if (got !== hold_v || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL hold: got out_valid=%b cout/sum=%h, want out_valid=0 cout/sum=%h",
                             bus.out_valid, got, hold_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] big;
        checks       = 0;
        errors       = 0;
        hold_v       = '0;
        started      = 1'b0;
        rst_at_edge  = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;

        drive(1'b1, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        idle(3);

        // Directed adds, back-to-back.
        drive(1'b0, 1'b1, 24'd98,      24'd48,      1'b0);
        drive(1'b0, 1'b1, 24'd538,     24'd34849,   1'b1);
        drive(1'b0, 1'b1, 24'd65793,   24'd8723,    1'b0);
        drive(1'b0, 1'b1, 24'd2746128, 24'd2141202, 1'b1);
        big = 32'd34335808;
        drive(1'b0, 1'b1, big[ADD_W-1:0], 24'd284399, 1'b0);
        drive(1'b0, 1'b1, 24'hFFFFFF,  24'h000000,  1'b1);
        drive(1'b0, 1'b1, 24'hFFFFFF,  24'hFFFFFF,  1'b1);
        drive(1'b0, 1'b1, 24'h800000,  24'h800000,  1'b0);
        drive(1'b0, 1'b1, 24'h000000,  24'h000000,  1'b0);
        drive(1'b0, 1'b1, 24'hFFFFFF,  24'h000001,  1'b0);

        // Hold with changing operands, then reset alongside a valid add.
        idle(4);
        drive(1'b0, 1'b1, 24'h123456, 24'h654321, 1'b1);
        drive(1'b1, 1'b1, 24'hABCDEF, 24'h111111, 1'b1);
        idle(3);

        // Random regression with random gaps.
        for (int n = 0; n < 10000; n++) begin
            drive(1'b0, ($urandom_range(0, 3) != 0), word_t'($urandom),
                  word_t'($urandom), 1'($urandom));
        end
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results never presented, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bk_adder_24.md
Name: bk_adder_24

Overview:
- 24-bit two-operand adder with carry-in, built as a Brent-Kung parallel-prefix carry tree.
- Result and carry-out are registered once at the output, so the block drops into clocked datapaths as a single-cycle arithmetic stage.
- Used wherever a 24-bit add with explicit carry-in/carry-out is needed; the Brent-Kung structure trades a little depth for low wiring and cell count.

Parameters:
- None. Width is fixed at 24; the prefix tree is laid out explicitly for 24 bits.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset (sampled on rising edge of clk)
- in_valid  input  1  qualifies a, b, cin in the current cycle
- a  input  24  operand A, unsigned
- b  input  24  operand B, unsigned
- cin  input  1  carry-in
- sum  output  24  registered (a + b + cin) mod 2^24
- cout  output  1  registered carry out of bit 23
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a rising edge with rst=1, sum=0, cout=0, out_valid=0. Reset has priority over in_valid.
- Latency is exactly 1 cycle. On each rising edge with rst=0:
  - out_valid <= in_valid.
  - If in_valid=1: {cout,sum} <= a+b+cin (25-bit result).
  - If in_valid=0: sum and cout hold their previous values.
- Throughput is one add per cycle; there is no backpressure.
- Bit-level carry logic:
  - Per-bit generate/propagate: g[i]=a[i]&b[i]; p[i]=a[i]^b[i].
  - cin folded into bit 0: G0 = g[0] | (p[0]&cin).
- Prefix operator: (G,P)o(G',P') = (G | P&G', P&P').
- Brent-Kung tree, up-sweep: combine spans of 2, 4, 8, 16 at bit indices i where (i+1) is a multiple of the span (bits 1,3,5…; 3,7,11…; 7,15,23; 15).
- Down-sweep: fill the remaining group carries in decreasing span (8, 4, 2, 1), ending with every bit holding G[i:0]. Bits above 23 are not instantiated (no padding cells).
- Sum and carry-out:
  - C[0]=cin, C[i]=G[i-1:0].
  - sum[i]=p[i]^C[i].
  - cout=G[23:0] with cin included.
- The adder is purely combinational between the input ports and the output register; no input register.
- Overflow wraps modulo 2^24; overflow is signalled only through cout.
- Boundaries:
  - a=b=0xFFFFFF, cin=1 -> sum=0xFFFFFF, cout=1.
  - a=0xFFFFFF, b=0, cin=1 -> sum=0, cout=1 (full-length carry ripple through the tree).
- rst asserted mid-stream: the registered result is discarded; out_valid is 0 on the next cycle.
- No X propagation from unused inputs when in_valid=0; the outputs hold.

Decomposition:
- Shared package: constant ADD_W=24.
- Natural sub-module: bk_prefix_cell. It takes (G_hi,P_hi,G_lo,P_lo) and returns (G,P); the tree instantiates it per node.
- Optional gray-cell variant that outputs G only, for down-sweep terminal nodes.
- The top level holds the g/p generation, the tree wiring, the sum XOR and the output register.

Test Plan:
- Apply rst=1 for 2 cycles -> sum=0, cout=0, out_valid=0. Release rst -> outputs unchanged until the first in_valid.
- Basic adds, each result one cycle after input with out_valid=1, inputs issued back-to-back with in_valid=1:
  - a=98, b=48, cin=0 -> sum=146, cout=0.
  - a=538, b=34849, cin=1 -> sum=35388, cout=0.
  - a=65793, b=8723, cin=0 -> sum=74516, cout=0.
  - a=2746128, b=2141202, cin=1 -> sum=4887331, cout=0.
- Truncation: drive a=781376 (24-bit image of 34335808), b=284399, cin=0 -> sum=1065775, cout=0.
- Carry-out and wrap:
  - a=0xFFFFFF, b=0, cin=1 -> sum=0, cout=1.
  - a=0xFFFFFF, b=0xFFFFFF, cin=1 -> sum=0xFFFFFF, cout=1.
  - a=0x800000, b=0x800000, cin=0 -> sum=0, cout=1.
- Hold and reset:
  - in_valid=0 with changing a/b -> sum/cout hold, out_valid=0.
  - Assert rst in the same cycle as a valid add -> next cycle outputs 0, out_valid=0.
- Random regression: 10k random a, b, cin with random in_valid gaps -> {cout,sum} always equals the registered a+b+cin, one cycle later.
